jk_reg_bank: RTL

//   WIDTH-bit bank of JK flip-flops with a common clock, async reset and clock enable.

---
 rtl/jk_bank_pkg.sv | 15 +
 rtl/jk_cell.sv | 39 +++
 rtl/jk_reg_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
// Shared mode encodings and the JK next-state rule for the jk_reg_bank block.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    function automatic logic jk_next(input logic q_cur, input logic j_in, input logic k_in);
        return (j_in & ~q_cur) | (~k_in & q_cur);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable and asynchronous active-high reset.
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    // next state: JK rule when enabled, otherwise hold
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = jk_next(q_q, j, k);
        end else begin
            q_d = q_q;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank: JK / COUNT / SHIFT / LOAD modes built from jk_cell.
// Define JK_REG_BANK_SATURATE_EN to make COUNT saturate at all-ones instead of wrapping.
module jk_reg_bank
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             ser_out,
    output logic             tc,
    output logic             changed
);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] qb_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] q_next_s;
    logic             all_ones_s;
    logic             changed_q;
    logic             changed_d;

    assign all_ones_s = &q_s;
    assign shift_s    = {q_s[WIDTH-2:0], ser_in};

    // ripple carry: bit i toggles when all lower bits are one
    always_comb begin
        carry_s    = '0;
        carry_s[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry_s[i] = carry_s[i-1] & q_s[i-1];
        end
    end

    // per-mode J/K steering into the cells
    always_comb begin
        j_s = '0;
        k_s = '0;
        case (mode_e'(mode))
            MODE_JK: begin
                j_s = j;
                k_s = k;
            end
            MODE_COUNT: begin
`ifdef JK_REG_BANK_SATURATE_EN
                if (all_ones_s) begin
                    j_s = '0;
                    k_s = '0;
                end else begin
                    j_s = carry_s;
                    k_s = carry_s;
                end
`else
                j_s = carry_s;
                k_s = carry_s;
`endif
            end
            MODE_SHIFT: begin
                j_s = shift_s;
                k_s = ~shift_s;
            end
            MODE_LOAD: begin
                j_s = j;
                k_s = ~j;
            end
            default: begin
                j_s = '0;
                k_s = '0;
            end
        endcase
    end

    // predicted cell state after the edge, used only for the change flag
    always_comb begin
        q_next_s = q_s;
        for (int i = 0; i < WIDTH; i++) begin
            q_next_s[i] = jk_next(q_s[i], j_s[i], k_s[i]);
        end
        changed_d = en & (q_next_s != q_s);
    end

    // change-pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .j     (j_s[g]),
            .k     (k_s[g]),
            .q     (q_s[g]),
            .qb    (qb_s[g])
        );
    end

    assign q       = q_s;
    assign qb      = qb_s;
    assign ser_out = q_s[WIDTH-1];
    assign tc      = en & (mode == MODE_COUNT) & all_ones_s;
    assign changed = changed_q;

endmodule
